// File: rtl/pe_axpy.sv
// pe_axpy: scalar-times-vector accumulate, y[i] <= sat(y[i] + ((s * x[i]) >>> FRAC)).
// One element per clock; the y bank is an array of per-element register lanes.

module pe_axpy_lane (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        we,
   input  logic [31:0] d,
   output logic [31:0] q
);
   always_ff @(posedge clk) begin
      if (rst || clr) q <= '0;
      else if (we)    q <= d;
   end
endmodule

module pe_axpy #(
   parameter int N    = 64,
   parameter int FRAC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                clear_acc,
   input  logic signed [63:0]  s,
   input  logic [N-1:0][31:0]  x,
   output logic [N-1:0][31:0]  y,
   output logic                busy,
   output logic                done,
   output logic                ovf
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [IW-1:0]      idx;
   logic signed [63:0] s_q;
   logic [31:0]        xe, ye, wdata;
   logic signed [95:0] prod, sh;
   logic [96:0]        sum;
   logic               sat, last, idle_go, idle_clr, run;

   assign run      = (state == RUN);
   assign idle_go  = (state == IDLE) && start;
   assign idle_clr = (state == IDLE) && clear_acc;
   assign last     = (idx == IW'(N-1));

   assign xe   = x[idx];
   assign ye   = y[idx];
   assign prod = $signed({{32{s_q[63]}}, s_q}) * $signed({{64{xe[31]}}, xe});
   assign sh   = prod >>> FRAC;
   assign sum  = {sh[95], sh} + {{65{ye[31]}}, ye};
   // In range only when bits 96..31 are all copies of the sign.
   assign sat   = !((&sum[96:31]) || !(|sum[96:31]));
   assign wdata = sat ? (sum[96] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = run;
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         s_q <= '0;
         ovf <= 1'b0;
      end else begin
         if (idle_go) begin
            idx <= '0;
            s_q <= s;
         end else if (run) begin
            idx <= last ? '0 : idx + 1'b1;
         end
         if (idle_clr)       ovf <= 1'b0;
         else if (run && sat) ovf <= 1'b1;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      pe_axpy_lane u_lane (
         .clk (clk),
         .rst (rst),
         .clr (idle_clr),
         .we  (run && (idx == IW'(i))),
         .d   (wdata),
         .q   (y[i])
      );
   end
endmodule

// File: tb/tb_pe_axpy.sv
// Randomized self-checking bench for pe_axpy against a longint reference model.
module tb_pe_axpy;
   localparam int N = 64, FRAC = 16;

   logic clk = 1'b0, rst, start, clear_acc;
   logic signed [63:0] s;
   logic [N-1:0][31:0] x, y;
   logic busy, done, ovf;

   int n_chk = 0, n_fail = 0;
   int xm[N];
   int ym[N];
   bit om;

   pe_axpy #(.N(N), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc), .s(s),
      .x(x), .y(y), .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_x();
      for (int i = 0; i < N; i++) x[i] = xm[i];
   endtask

   // Reference: exact integer arithmetic, then clamp to the 32-bit range.
   task automatic model_elem(input int i, input longint sv);
      longint sm;
      sm = longint'(ym[i]) + ((sv * longint'(xm[i])) >>> FRAC);
      if (sm > 64'sd2147483647) begin ym[i] = 32'h7FFFFFFF; om = 1'b1; end
      else if (sm < -64'sd2147483648) begin ym[i] = 32'h80000000; om = 1'b1; end
      else ym[i] = int'(sm);
   endtask

   task automatic chk_all(input string tag);
      for (int i = 0; i < N; i++) chk($sformatf("%s y[%0d]", tag, i), $signed(y[i]), ym[i]);
      chk({tag, " ovf"}, ovf, om);
   endtask

   // mode 0: plain; 1: stray start pulses in RUN and DONE; 2: s scrambled during RUN
   task automatic do_pass(input longint sv, input bit clr, input int mode, input string tag);
      int ndone = 0;
      s = sv; start = 1'b1; clear_acc = clr;
      tick();
      start = 1'b0; clear_acc = 1'b0;
      if (clr) begin
         for (int i = 0; i < N; i++) ym[i] = 0;
         om = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
         chk({tag, " busy_run"}, busy, 1);
         if (done) ndone++;
         if (mode == 1) start = (k == 10);
         if (mode == 2) s = {$urandom, $urandom};
         model_elem(k, sv);
         tick();
      end
      start = 1'b0;
      chk({tag, " done_early"}, ndone, 0);
      chk({tag, " done_pulse"}, done, 1);
      chk({tag, " busy_done"}, busy, 0);
      if (mode == 1) start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " done_drop"}, done, 0);
      chk({tag, " busy_idle"}, busy, 0);
      if (mode == 1) begin
         tick();
         chk({tag, " no_restart"}, busy, 0);
      end
      chk_all(tag);
   endtask

   task automatic rand_x();
      for (int i = 0; i < N; i++) xm[i] = int'($urandom) >>> $urandom_range(0, 31);
      load_x();
   endtask

   function automatic longint rand_s();
      return longint'(int'($urandom)) >>> $urandom_range(0, 31);
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; clear_acc = 1'b0; s = '0; x = '0; om = 1'b0;
      for (int i = 0; i < N; i++) begin xm[i] = 0; ym[i] = 0; end
      tick(); tick();
      rst = 1'b0;
      chk_all("reset");
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);

      for (int i = 0; i < N; i++) xm[i] = i;
      load_x();
      do_pass(65536, 1'b1, 0, "t1");
      do_pass(-131072, 1'b0, 0, "t2");
      chk("t2 y63", $signed(y[63]), -63);

      for (int i = 0; i < N; i++) xm[i] = 0;
      xm[5] = 1 << 20;
      load_x();
      do_pass(longint'(1) << 40, 1'b1, 0, "t3a");
      chk("t3a y5", $signed(y[5]), 64'sd2147483647);
      chk("t3a ovf", ovf, 1);
      xm[5] = -(1 << 20);
      load_x();
      do_pass(longint'(1) << 40, 1'b0, 0, "t3b");
      chk("t3b y5", $signed(y[5]), -64'sd2147483648);

      rand_x();
      do_pass(rand_s(), 1'b1, 1, "t4");

      s = rand_s(); start = 1'b1; tick(); start = 1'b0;
      repeat (10) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < N; i++) ym[i] = 0;
      om = 1'b0;
      chk_all("t5rst");
      chk("t5 busy", busy, 0);
      chk("t5 done", done, 0);
      do_pass(rand_s(), 1'b0, 0, "t5run");

      rand_x();
      do_pass(rand_s(), 1'b1, 2, "t6");

      for (int r = 0; r < 8; r++) begin
         rand_x();
         do_pass(rand_s(), 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
